fpga_clk_cfg_ctrl: RTL

Reconfiguration controller for the FPGA clock manager. It arbitrates the three clock-configuration request ports (soc, per, cluster) from the APB/FLL-config side and serializes them onto the single DRP port of the Xilinx MMCM. It sequences MMCM reset and relock after an "apply" command and reports per-domain lock status. It sits between the SoC clock-config interconnect and the clocking-wizard instance in the FPGA clock generator.

---
 rtl/fpga_clk_cfg_ctrl_if.sv | 20 ++
 rtl/fpga_clk_cfg_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fpga_clk_cfg_ctrl_if.sv
// Clock-configuration request port: one instance per clock domain (soc, per, cluster).
interface fpga_clk_cfg_ctrl_if;
  logic        cfg_req;
  logic [1:0]  cfg_add;
  logic [31:0] cfg_data;
  logic        cfg_wrn;
  logic        cfg_ack;
  logic [31:0] cfg_r_data;
  logic        cfg_lock;

  modport master (
    output cfg_req, cfg_add, cfg_data, cfg_wrn,
    input  cfg_ack, cfg_r_data, cfg_lock
  );

  modport slave (
    input  cfg_req, cfg_add, cfg_data, cfg_wrn,
    output cfg_ack, cfg_r_data, cfg_lock
  );
endinterface

// File: rtl/fpga_clk_cfg_ctrl.sv
// fpga_clk_cfg_ctrl: round-robin arbiter for three clock-config ports, serialized onto
// the MMCM DRP port, plus the MMCM reset/relock sequence triggered by an apply write.
module fpga_clk_cfg_ctrl #(
  parameter logic [6:0]  DRP_BASE_SOC     = 7'h08,
  parameter logic [6:0]  DRP_BASE_PER     = 7'h0A,
  parameter logic [6:0]  DRP_BASE_CLUSTER = 7'h0C,
  parameter int unsigned RST_CYCLES       = 8,
  parameter int unsigned LOCK_TIMEOUT     = 65536
) (
  input  logic                ref_clk_i,
  input  logic                rstn_glob_i,
  fpga_clk_cfg_ctrl_if.slave  soc_cfg,
  fpga_clk_cfg_ctrl_if.slave  per_cfg,
  fpga_clk_cfg_ctrl_if.slave  cluster_cfg,
  output logic [6:0]          drp_addr_o,
  output logic [15:0]         drp_di_o,
  output logic                drp_en_o,
  output logic                drp_we_o,
  input  logic [15:0]         drp_do_i,
  input  logic                drp_rdy_i,
  output logic                mmcm_rst_o,
  input  logic                mmcm_locked_i,
  output logic                timeout_o
);

  localparam int unsigned NPORT   = 3;
  localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RST, S_LOCK, S_ACK} t_state;

  typedef struct packed {
    logic [1:0]  add;
    logic [15:0] data;
    logic        wrn;
  } t_cfg_req;

  t_state            r_state, w_state_nxt;
  logic [1:0]        r_gnt, w_port_nxt;
  logic [1:0]        r_last;
  logic              r_cmd_wrn;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic [31:0]       w_resp;
  logic              w_ld_cmd;

  logic              r_drp_en, r_drp_we, r_mmcm_rst, r_lock;
  logic [6:0]        r_drp_addr;
  logic [15:0]       r_drp_di;
  logic [NPORT-1:0]  r_ack;
  logic [31:0]       r_rdata [NPORT];

  logic [3:0]        w_req;
  t_cfg_req          w_req_pl [4];
  logic              w_gnt_vld;
  logic [1:0]        w_gnt_idx, w_cand;
  t_cfg_req          w_gnt_pl;
  logic              w_unused_data;

  // Gather the three request ports into indexable form (slot 3 is an idle filler)
  assign w_req       = {1'b0, cluster_cfg.cfg_req, per_cfg.cfg_req, soc_cfg.cfg_req};
  assign w_req_pl[0] = '{add: soc_cfg.cfg_add,     data: soc_cfg.cfg_data[15:0],     wrn: soc_cfg.cfg_wrn};
  assign w_req_pl[1] = '{add: per_cfg.cfg_add,     data: per_cfg.cfg_data[15:0],     wrn: per_cfg.cfg_wrn};
  assign w_req_pl[2] = '{add: cluster_cfg.cfg_add, data: cluster_cfg.cfg_data[15:0], wrn: cluster_cfg.cfg_wrn};
  assign w_req_pl[3] = '0;
  assign w_gnt_pl    = w_req_pl[w_gnt_idx];
  assign w_unused_data = ^{soc_cfg.cfg_data[31:16], per_cfg.cfg_data[31:16], cluster_cfg.cfg_data[31:16]};

  function automatic logic [6:0] f_base(input logic [1:0] idx);
    case (idx)
      2'd0:    f_base = DRP_BASE_SOC;
      2'd1:    f_base = DRP_BASE_PER;
      default: f_base = DRP_BASE_CLUSTER;
    endcase
  endfunction

  // Round-robin pick: the port right after the last granted one has top priority
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_last;
    w_cand    = r_last;
    for (int k = 3; k >= 1; k--) begin
      w_cand = 2'((int'(r_last) + k) % 3);
      if (w_req[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  // Next-state, response data and counter control
  always_comb begin
    w_state_nxt   = r_state;
    w_port_nxt    = r_gnt;
    w_resp        = 32'h0;
    w_cnt_nxt     = '0;
    w_timeout_nxt = r_timeout;
    w_ld_cmd      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_ld_cmd   = 1'b1;
          w_port_nxt = w_gnt_idx;
          if (!w_gnt_pl.add[1]) begin
            w_state_nxt = S_ISSUE;
          end else if (w_gnt_pl.add[0] && !w_gnt_pl.wrn) begin
            w_state_nxt   = S_RST;
            w_timeout_nxt = 1'b0;
          end else begin
            w_state_nxt = S_ACK;
            w_resp      = {30'h0, r_timeout, mmcm_locked_i};
          end
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (drp_rdy_i) begin
          w_state_nxt = S_ACK;
          w_resp      = r_cmd_wrn ? {16'h0, drp_do_i} : 32'h0;
        end
      end
      S_RST: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
          w_state_nxt = S_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      S_LOCK: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (mmcm_locked_i) begin
          w_state_nxt   = S_ACK;
          w_timeout_nxt = 1'b0;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_state_nxt   = S_ACK;
          w_timeout_nxt = 1'b1;
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, arbitration pointer and captured command
  always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      r_state   <= S_IDLE;
      r_gnt     <= 2'd0;
      r_last    <= 2'd2;
      r_cmd_wrn <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_port_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
      if (w_ld_cmd) begin
        r_cmd_wrn <= w_gnt_pl.wrn;
        r_last    <= w_gnt_idx;
      end
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      r_drp_en   <= 1'b0;
      r_drp_we   <= 1'b0;
      r_drp_addr <= 7'h0;
      r_drp_di   <= 16'h0;
      r_mmcm_rst <= 1'b0;
      r_lock     <= 1'b0;
      r_ack      <= '0;
      for (int i = 0; i < NPORT; i++) r_rdata[i] <= 32'h0;
    end else begin
      r_drp_en   <= (w_state_nxt == S_ISSUE);
      r_mmcm_rst <= (w_state_nxt == S_RST);
      r_lock     <= mmcm_locked_i && !((w_state_nxt == S_RST) || (w_state_nxt == S_LOCK));
      if (w_state_nxt == S_ISSUE) begin
        r_drp_we   <= !w_gnt_pl.wrn;
        r_drp_addr <= f_base(w_gnt_idx) + 7'(w_gnt_pl.add[0]);
        r_drp_di   <= w_gnt_pl.data;
      end
      for (int i = 0; i < NPORT; i++) begin
        r_ack[i] <= (w_state_nxt == S_ACK) && (w_port_nxt == 2'(i));
        if ((w_state_nxt == S_ACK) && (w_port_nxt == 2'(i))) r_rdata[i] <= w_resp;
      end
    end
  end

  assign drp_en_o   = r_drp_en;
  assign drp_we_o   = r_drp_we;
  assign drp_addr_o = r_drp_addr;
  assign drp_di_o   = r_drp_di;
  assign mmcm_rst_o = r_mmcm_rst;
  assign timeout_o  = r_timeout;

  assign soc_cfg.cfg_ack        = r_ack[0];
  assign per_cfg.cfg_ack        = r_ack[1];
  assign cluster_cfg.cfg_ack    = r_ack[2];
  assign soc_cfg.cfg_r_data     = r_rdata[0];
  assign per_cfg.cfg_r_data     = r_rdata[1];
  assign cluster_cfg.cfg_r_data = r_rdata[2];
  assign soc_cfg.cfg_lock       = r_lock;
  assign per_cfg.cfg_lock       = r_lock;
  assign cluster_cfg.cfg_lock   = r_lock;

endmodule
